// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: sequences SISO half-iterations, feeds input samples, tracks extrinsic writes.
// Latency: first rd_valid two cycles after an accepted valid_blklen; done one cycle after the final NEXT.
// Backpressure: none on the feed side; DRAIN waits for the SISO to return K extrinsics before the next half.
//
// Ports: clk/rst (async active-low); blklen/valid_blklen start request; abort; valid_extrinsic SISO strobe;
//        stop_req early-stop input; siso_blklen/siso_valid_blklen length load; rd_addr/rd_phase/rd_valid/apr_valid
//        sample feed; half_sel decoder select; ext_wr_addr/ext_wr_en extrinsic write; iter_cnt/busy/done/err status.
// Optional feature: define TURBO_EARLY_STOP_EN to let stop_req end decoding after any decoder-2 half.
module turbo_iter_ctrl #(
    parameter int MAX_ITER   = 8,
    parameter int MIN_BLKLEN = 40,
    parameter int MAX_BLKLEN = 6144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] blklen,
    input  logic        valid_blklen,
    input  logic        abort,
    input  logic        valid_extrinsic,
    input  logic        stop_req,
    output logic [15:0] siso_blklen,
    output logic        siso_valid_blklen,
    output logic [12:0] rd_addr,
    output logic        rd_phase,
    output logic        rd_valid,
    output logic        apr_valid,
    output logic        half_sel,
    output logic [12:0] ext_wr_addr,
    output logic        ext_wr_en,
    output logic [3:0]  iter_cnt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, NEXT, DONE} state_t;

    localparam logic [15:0] MIN_K    = 16'(MIN_BLKLEN);
    localparam logic [15:0] MAX_K    = 16'(MAX_BLKLEN);
    localparam logic [3:0]  MAX_IT   = 4'(MAX_ITER);

    state_t      state_q, state_d;
    logic [15:0] k_q, k_d;
    logic        half_q, half_d;
    logic [3:0]  iter_q, iter_d;
    logic [12:0] addr_q, addr_d;
    logic        phase_q, phase_d;
    logic [12:0] ext_q, ext_d;
    logic        err_q, err_d;

    logic        cnt_en;
    logic        ext_full;
    logic        last_pair;
    logic        k_ok;

    // Extrinsics are only meaningful while a half-iteration is in flight.
    assign cnt_en    = (state_q == LOAD) || (state_q == FEED) || (state_q == DRAIN) || (state_q == NEXT);
    assign ext_full  = ({3'b000, ext_q} == k_q);
    assign last_pair = ({3'b000, addr_q} == (k_q - 16'd1));
    assign k_ok      = (blklen >= MIN_K) && (blklen <= MAX_K);

`ifndef TURBO_EARLY_STOP_EN
    logic stop_req_unused;
    assign stop_req_unused = stop_req;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        half_d  = half_q;
        iter_d  = iter_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        ext_d   = ext_q;
        err_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            half_d  = 1'b0;
            iter_d  = 4'd0;
            addr_d  = 13'd0;
            phase_d = 1'b0;
            ext_d   = 13'd0;
        end else begin
            // A strobe beyond K is a SISO protocol error: flagged, not written, not counted.
            if (valid_extrinsic && cnt_en) begin
                if (ext_full) begin
                    err_d = 1'b1;
                end else begin
                    ext_d = ext_q + 13'd1;
                end
            end
            if (valid_blklen && (state_q != IDLE)) begin
                err_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (valid_blklen) begin
                        if (k_ok) begin
                            k_d     = blklen;
                            half_d  = 1'b0;
                            iter_d  = 4'd0;
                            addr_d  = 13'd0;
                            phase_d = 1'b0;
                            ext_d   = 13'd0;
                            state_d = LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                LOAD: state_d = FEED;
                FEED: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        // rd_addr parks on K-1 after the last pair; NEXT clears it.
                        if (last_pair) begin
                            state_d = ext_full ? NEXT : DRAIN;
                        end else begin
                            addr_d = addr_q + 13'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (ext_full) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    ext_d   = 13'd0;
                    addr_d  = 13'd0;
                    phase_d = 1'b0;
                    if (!half_q) begin
                        half_d  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        half_d  = 1'b0;
                        iter_d  = iter_q + 4'd1;
                        state_d = ((iter_q + 4'd1) == MAX_IT) ? DONE : LOAD;
`ifdef TURBO_EARLY_STOP_EN
                        if (stop_req) begin
                            state_d = DONE;
                        end
`endif
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= 16'd0;
            half_q  <= 1'b0;
            iter_q  <= 4'd0;
            addr_q  <= 13'd0;
            phase_q <= 1'b0;
            ext_q   <= 13'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            half_q  <= half_d;
            iter_q  <= iter_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            ext_q   <= ext_d;
            err_q   <= err_d;
        end
    end

    assign siso_blklen       = k_q;
    assign siso_valid_blklen = (state_q == LOAD);
    assign rd_valid          = (state_q == FEED);
    assign rd_phase          = phase_q;
    assign rd_addr           = addr_q;
    assign apr_valid         = rd_valid & phase_q;
    assign half_sel          = half_q;
    assign ext_wr_addr       = ext_q;
    assign ext_wr_en         = valid_extrinsic && cnt_en && !ext_full;
    assign iter_cnt          = iter_q;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE) && !abort;
    assign err               = err_q;

endmodule

// File: doc/turbo_iter_ctrl.md
TURBO_ITER_CTRL -- requirements
Module: turbo_iter_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 8, giving the number of full iterations (two half-iterations each), range 1..15.
REQ-002 The block SHALL have parameter MIN_BLKLEN, default 40, the smallest accepted block length.
REQ-003 The block SHALL have parameter MAX_BLKLEN, default 6144, the largest accepted block length.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 blklen  in  16  block length K; sampled only when valid_blklen=1.
REQ-007 valid_blklen  in  1  one-cycle start request.
REQ-008 abort  in  1  synchronous abort; forces IDLE.
REQ-009 valid_extrinsic  in  1  SISO extrinsic output strobe.
REQ-010 stop_req  in  1  early-stop request (CRC pass); used only under the macro.
REQ-011 siso_blklen  out  16  latched K driven to SISO.
REQ-012 siso_valid_blklen  out  1  one-cycle length load pulse to SISO.
REQ-013 rd_addr  out  13  bit index k of the current input sample.
REQ-014 rd_phase  out  1  0 = systematic sample, 1 = parity sample.
REQ-015 rd_valid  out  1  drives SISO valid_in.
REQ-016 apr_valid  out  1  apriori strobe to SISO, asserted with rd_phase=1.
REQ-017 half_sel  out  1  0 = decoder 1 (natural order), 1 = decoder 2 (interleaved order, mapped externally).
REQ-018 ext_wr_addr  out  13  extrinsic memory write index.
REQ-019 ext_wr_en  out  1  extrinsic memory write enable.
REQ-020 iter_cnt  out  4  completed full iterations.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 done  out  1  one-cycle completion pulse.
REQ-023 err  out  1  one-cycle error pulse.

Function
REQ-024 The FSM SHALL have states IDLE, LOAD, FEED, DRAIN, NEXT, DONE.
REQ-025 In IDLE, a valid_blklen with MIN_BLKLEN<=blklen<=MAX_BLKLEN SHALL latch K, set half_sel=0 and iter_cnt=0, and go to LOAD; an out-of-range K SHALL pulse err and stay in IDLE.
REQ-026 LOAD SHALL last one cycle, assert siso_valid_blklen, and go to FEED; the first rd_valid SHALL occur 2 cycles after the accepting valid_blklen.
REQ-027 FEED SHALL assert rd_valid for exactly 2*K consecutive cycles; rd_phase SHALL toggle every cycle starting at 0; rd_addr SHALL increment after each rd_phase=1 cycle, 0..K-1.
REQ-028 apr_valid SHALL equal rd_valid AND rd_phase.
REQ-029 The extrinsic counter SHALL count valid_extrinsic in any state other than IDLE and DONE; ext_wr_en=valid_extrinsic and ext_wr_addr=counter, both combinational.
REQ-030 After the last FEED cycle, the FSM SHALL go to DRAIN, or directly to NEXT if the extrinsic count already equals K.
REQ-031 The FSM SHALL leave DRAIN for NEXT in the cycle after the extrinsic count reaches K.
REQ-032 A valid_extrinsic received after the count has reached K SHALL pulse err, suppress ext_wr_en, and leave the count unchanged.
REQ-033 NEXT SHALL last one cycle and clear the extrinsic counter and rd_addr.
REQ-034 When half_sel=0, NEXT SHALL set half_sel=1 and go to LOAD.
REQ-035 When half_sel=1, NEXT SHALL increment iter_cnt and set half_sel=0; it SHALL go to DONE if the new iter_cnt equals MAX_ITER, otherwise to LOAD.
REQ-036 DONE SHALL pulse done for one cycle and return to IDLE; iter_cnt SHALL hold its value until the next accepted start.
REQ-037 A valid_blklen while busy=1 SHALL be ignored and SHALL pulse err.
REQ-038 abort=1 in any state SHALL force IDLE on the next edge, clear all strobes and counters, and SHALL NOT pulse done; abort SHALL take priority over valid_blklen in the same cycle.

Reset
REQ-039 While rst=0, the state SHALL be IDLE and every output and counter SHALL be 0, including siso_blklen and iter_cnt.
REQ-040 Deassertion of rst mid-operation SHALL resume from IDLE only; no partial block is resumed.

Configuration
REQ-041 With macro TURBO_EARLY_STOP_EN defined, stop_req=1 in a NEXT cycle with half_sel=1 SHALL increment iter_cnt and go to DONE regardless of MAX_ITER.
REQ-042 Without TURBO_EARLY_STOP_EN, stop_req SHALL be ignored and exactly MAX_ITER iterations SHALL run.

Verification
REQ-043 K=512, MAX_ITER=8, SISO model returns 512 extrinsics per half -> 16 siso_valid_blklen pulses, 1024 rd_valid cycles per half, done with iter_cnt=8.
REQ-044 blklen=39 or 6145 at valid_blklen -> err pulse, busy stays 0; K=6144 -> accepted, rd_addr reaches 6143.
REQ-045 Extrinsic latency longer than FEED (SISO lags by 100 cycles) -> DRAIN entered, exit after the 512th valid_extrinsic; 513th strobe -> err, no ext_wr_en.
REQ-046 abort asserted mid-FEED of iteration 3 -> IDLE the next cycle, no done; a new K=512 start then runs cleanly from iter_cnt=0.
REQ-047 TURBO_EARLY_STOP_EN defined, stop_req=1 at the end of iteration 2's decoder-2 half -> done with iter_cnt=2; macro undefined -> iter_cnt=8.
REQ-048 rst pulsed low mid-DRAIN -> all outputs 0 asynchronously, state IDLE after release.
